// File: rtl/multiply_accumulate_behavioural_pkg.sv
// Shared constants for the DSP48E1-style multiply-accumulate slice:
// default widths and op_mode/in_mode field encodings.
package multiply_accumulate_behavioural_pkg;

  localparam int DEFAULT_DATA_WIDTH        = 16;
  localparam int DEFAULT_COEFFICIENT_WIDTH = 16;
  localparam int DEFAULT_CARRY_WIDTH       = 48;

  localparam logic [1:0] OPMODE_X_M = 2'b01;
  localparam logic [1:0] OPMODE_Y_M = 2'b01;

  typedef enum logic [2:0] {
    OPMODE_Z_ZERO = 3'b000,
    OPMODE_Z_PCIN = 3'b001,
    OPMODE_Z_P    = 3'b010
  } opmode_z_e;

  localparam int INMODE_A1_SEL = 0;

  function automatic logic opmode_selects_m(input logic [6:0] op_mode);
    return (op_mode[1:0] == OPMODE_X_M) && (op_mode[3:2] == OPMODE_Y_M);
  endfunction

endpackage

// File: rtl/mac_delay_reg.sv
// Short register chain with an individual enable per stage; stage 0 loads
// i_data, later stages shift from their predecessor.
module mac_delay_reg #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [DEPTH-1:0] i_enable,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_first,
  output logic [WIDTH-1:0] o_last
);

  logic [DEPTH-1:0][WIDTH-1:0] r_taps;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      always_ff @(posedge clock) begin
        if (reset)          r_taps[g] <= '0;
        else if (i_enable[g]) r_taps[g] <= i_data;
      end
    end else begin : g_tail
      always_ff @(posedge clock) begin
        if (reset)          r_taps[g] <= '0;
        else if (i_enable[g]) r_taps[g] <= r_taps[g-1];
      end
    end
  end

  assign o_first = r_taps[0];
  assign o_last  = r_taps[DEPTH-1];

endmodule

// File: rtl/multiply_accumulate_behavioural.sv
// One systolic-FIR MAC slice: data/coefficient pipelines, M register,
// post-adder into P with carry cascade, scaled output on the last slice.
module multiply_accumulate_behavioural
  import multiply_accumulate_behavioural_pkg::*;
#(
  parameter int DATA_WIDTH               = DEFAULT_DATA_WIDTH,
  parameter int COEFFICIENT_WIDTH        = DEFAULT_COEFFICIENT_WIDTH,
  parameter int CARRY_WIDTH              = DEFAULT_CARRY_WIDTH,
  parameter int OUTPUT_OFFSET            = 0,
  parameter int DATA_IN_NUMBER_REGS      = 1,
  parameter int COEFFICIENTS_NUMBER_REGS = 2,
  parameter int USE_SILICON_CARRY        = 1,
  parameter int FIRST_IN_CHAIN           = 0,
  parameter int LAST_IN_CHAIN            = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic [COEFFICIENT_WIDTH-1:0] coefficient_in,
  input  logic [CARRY_WIDTH-1:0]       carry_in,
  output logic [CARRY_WIDTH-1:0]       carry_out,
  output logic [DATA_WIDTH-1:0]        data_carry,
  output logic [DATA_WIDTH-1:0]        data_out,
  input  logic                         ce_calculate,
  input  logic                         ce_coefficient,
  input  logic [6:0]                   op_mode,
  input  logic [4:0]                   in_mode
);

  localparam int PRODUCT_WIDTH = DATA_WIDTH + COEFFICIENT_WIDTH;
  localparam int OUT_LSB       = COEFFICIENT_WIDTH - 1 + OUTPUT_OFFSET;
  localparam bit unused_silicon_carry = (USE_SILICON_CARRY != 0);

  logic                                  w_unused_in_mode;
  logic [DATA_WIDTH-1:0]                 w_d_first;
  logic [DATA_WIDTH-1:0]                 w_d_last;
  logic [COEFFICIENT_WIDTH-1:0]          w_unused_coef_first;
  logic [COEFFICIENT_WIDTH-1:0]          w_coef_last;
  logic [COEFFICIENTS_NUMBER_REGS-1:0]   w_coef_en;
  logic signed [DATA_WIDTH-1:0]          w_mult_data;
  logic signed [COEFFICIENT_WIDTH-1:0]   w_mult_coef;
  logic signed [CARRY_WIDTH-1:0]         w_xy;
  logic signed [CARRY_WIDTH-1:0]         w_z;
  logic signed [PRODUCT_WIDTH-1:0]       r_m;
  logic signed [CARRY_WIDTH-1:0]         r_p;

  assign w_unused_in_mode = ^in_mode[4:1];

  mac_delay_reg #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DATA_IN_NUMBER_REGS)
  ) u_data_regs (
    .clock    (clock),
    .reset    (reset),
    .i_enable ({DATA_IN_NUMBER_REGS{ce_calculate}}),
    .i_data   (data_in),
    .o_first  (w_d_first),
    .o_last   (w_d_last)
  );

  // Coefficients survive reset so taps persist across frames; reset still
  // blocks a stage-1 load, while later stages shift every clock.
  always_comb begin
    w_coef_en    = '1;
    w_coef_en[0] = ce_coefficient & ~reset;
  end

  mac_delay_reg #(
    .WIDTH (COEFFICIENT_WIDTH),
    .DEPTH (COEFFICIENTS_NUMBER_REGS)
  ) u_coef_regs (
    .clock    (clock),
    .reset    (1'b0),
    .i_enable (w_coef_en),
    .i_data   (coefficient_in),
    .o_first  (w_unused_coef_first),
    .o_last   (w_coef_last)
  );

  assign w_mult_data = in_mode[INMODE_A1_SEL] ? w_d_first : w_d_last;
  assign w_mult_coef = w_coef_last;
  assign w_xy        = opmode_selects_m(op_mode) ? CARRY_WIDTH'(r_m) : '0;

  always_comb begin
    w_z = '0;
    case (op_mode[6:4])
      OPMODE_Z_ZERO: w_z = '0;
      OPMODE_Z_PCIN: w_z = (FIRST_IN_CHAIN != 0) ? '0 : carry_in;
      OPMODE_Z_P:    w_z = r_p;
      default:       w_z = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_m <= '0;
      r_p <= '0;
    end else if (ce_calculate) begin
      r_m <= w_mult_data * w_mult_coef;
      r_p <= w_xy + w_z;
    end
  end

  assign carry_out  = r_p;
  assign data_carry = w_d_last;

  if (LAST_IN_CHAIN != 0) begin : g_out
    assign data_out = r_p[OUT_LSB +: DATA_WIDTH];
  end else begin : g_no_out
    assign data_out = '0;
  end

endmodule

// File: tb/tb_multiply_accumulate_behavioural.sv
// Self-checking bench: three slice configurations share one stimulus stream
// and are compared against a transaction-level reference model.
module tb_multiply_accumulate_behavioural;

  localparam int N = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic [15:0] coefficient_in;
  logic [47:0] carry_in;
  logic        ce_calculate;
  logic        ce_coefficient;
  logic [6:0]  op_mode;
  logic [4:0]  in_mode;

  logic [N-1:0][47:0] co;
  logic [N-1:0][15:0] dout;
  logic [N-1:0][15:0] dcar;

  // per-instance configuration, mirrored from the instantiations below
  int dregs [N] = '{1, 2, 2};
  int cregs [N] = '{2, 1, 2};
  int first [N] = '{0, 1, 0};
  int last  [N] = '{1, 1, 0};
  int lsb   [N] = '{15, 13, 15};

  // reference state: data samples seen, coefficients seen, product, sum
  logic signed [15:0] md [N][2];
  logic signed [15:0] mc [N][2];
  longint             mm [N];
  longint             mp [N];

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  multiply_accumulate_behavioural #(
    .DATA_IN_NUMBER_REGS(1), .COEFFICIENTS_NUMBER_REGS(2), .OUTPUT_OFFSET(0),
    .FIRST_IN_CHAIN(0), .LAST_IN_CHAIN(1)
  ) dut_a (
    .clock(clock), .reset(reset), .data_in(data_in), .coefficient_in(coefficient_in),
    .carry_in(carry_in), .carry_out(co[0]), .data_carry(dcar[0]), .data_out(dout[0]),
    .ce_calculate(ce_calculate), .ce_coefficient(ce_coefficient),
    .op_mode(op_mode), .in_mode(in_mode)
  );

  multiply_accumulate_behavioural #(
    .DATA_IN_NUMBER_REGS(2), .COEFFICIENTS_NUMBER_REGS(1), .OUTPUT_OFFSET(-2),
    .FIRST_IN_CHAIN(1), .LAST_IN_CHAIN(1)
  ) dut_b (
    .clock(clock), .reset(reset), .data_in(data_in), .coefficient_in(coefficient_in),
    .carry_in(carry_in), .carry_out(co[1]), .data_carry(dcar[1]), .data_out(dout[1]),
    .ce_calculate(ce_calculate), .ce_coefficient(ce_coefficient),
    .op_mode(op_mode), .in_mode(in_mode)
  );

  multiply_accumulate_behavioural #(
    .DATA_IN_NUMBER_REGS(2), .COEFFICIENTS_NUMBER_REGS(2), .OUTPUT_OFFSET(0),
    .FIRST_IN_CHAIN(0), .LAST_IN_CHAIN(0)
  ) dut_c (
    .clock(clock), .reset(reset), .data_in(data_in), .coefficient_in(coefficient_in),
    .carry_in(carry_in), .carry_out(co[2]), .data_carry(dcar[2]), .data_out(dout[2]),
    .ce_calculate(ce_calculate), .ce_coefficient(ce_coefficient),
    .op_mode(op_mode), .in_mode(in_mode)
  );

  function automatic longint wrap48(input longint v);
    return (v <<< 16) >>> 16;
  endfunction

  task automatic model_update();
    for (int k = 0; k < N; k++) begin
      logic signed [15:0] dsel;
      logic signed [15:0] clast;
      longint xy;
      longint z;
      dsel  = in_mode[0] ? md[k][0] : md[k][dregs[k]-1];
      clast = mc[k][cregs[k]-1];
      if (reset) begin
        md[k][0] = '0;
        md[k][1] = '0;
        mm[k]    = 0;
        mp[k]    = 0;
      end else if (ce_calculate) begin
        xy = (op_mode[3:0] == 4'b0101) ? mm[k] : 0;
        case (op_mode[6:4])
          3'b001:  z = (first[k] != 0) ? 0 : longint'($signed(carry_in));
          3'b010:  z = mp[k];
          default: z = 0;
        endcase
        mp[k]    = wrap48(xy + z);
        mm[k]    = longint'(dsel) * longint'(clast);
        md[k][1] = md[k][0];
        md[k][0] = $signed(data_in);
      end
      mc[k][1] = mc[k][0];
      if (ce_coefficient && !reset) mc[k][0] = $signed(coefficient_in);
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  task automatic load_coef(input logic [15:0] c);
    ce_calculate   = 1'b0;
    ce_coefficient = 1'b1;
    coefficient_in = c;
    step();
    step();
    ce_coefficient = 1'b0;
  endtask

  task automatic run_mac(input logic [15:0] d, input logic [6:0] op, input int n);
    data_in      = d;
    op_mode      = op;
    in_mode      = 5'b00001;
    ce_calculate = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    for (int k = 0; k < N; k++) begin
      checks++;
      if (co[k] !== 48'h0 || dout[k] !== 16'h0 || dcar[k] !== 16'h0) begin
        errors++;
        $display("FAIL reset_state inst%0d: carry_out=%h data_out=%h data_carry=%h, required all zero",
                 k, co[k], dout[k], dcar[k]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_basic_multiply();
    load_coef(16'h4000);
    run_mac(16'h2000, 7'b0000101, 3);
    checks++;
    if (co[0] !== 48'h0000_0800_0000) begin
      errors++; $display("FAIL basic_p: carry_out=%h required 000008000000", co[0]);
    end
    checks++;
    if (dout[0] !== 16'h1000) begin
      errors++; $display("FAIL basic_dout: data_out=%h required 1000", dout[0]);
    end
    checks++;
    if (co[1] !== 48'h0000_0800_0000) begin
      errors++; $display("FAIL basic_p_d2: carry_out=%h required 000008000000", co[1]);
    end
    checks++;
    if (dout[1] !== 16'h4000) begin
      errors++; $display("FAIL offset_m2_dout: data_out=%h required 4000", dout[1]);
    end
    checks++;
    if (dout[2] !== 16'h0 || co[2] !== 48'h0000_0800_0000) begin
      errors++;
      $display("FAIL not_last_dout: data_out=%h carry_out=%h required 0000 / 000008000000", dout[2], co[2]);
    end
  endtask

  task automatic test_cascade();
    carry_in = 48'h0000_0000_0100;
    run_mac(16'h0000, 7'b0000000, 3);
    run_mac(16'h0000, 7'b0010101, 1);
    checks++;
    if (co[0] !== 48'h0000_0000_0100) begin
      errors++; $display("FAIL cascade_p: carry_out=%h required 000000000100", co[0]);
    end
    checks++;
    if (co[1] !== 48'h0) begin
      errors++; $display("FAIL cascade_first: carry_out=%h required 000000000000", co[1]);
    end
  endtask

  task automatic test_negative();
    load_coef(16'h0003);
    run_mac(16'hFFFF, 7'b0000101, 3);
    checks++;
    if (co[0] !== 48'hFFFF_FFFF_FFFD) begin
      errors++; $display("FAIL negative_p: carry_out=%h required fffffffffffd", co[0]);
    end
    checks++;
    if (dout[0] !== 16'hFFFF) begin
      errors++; $display("FAIL negative_dout: data_out=%h required ffff", dout[0]);
    end
  endtask

  task automatic test_accumulate();
    load_coef(16'h4000);
    run_mac(16'h2000, 7'b0000101, 3);
    run_mac(16'h2000, 7'b0100101, 2);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (co[k] !== 48'h0000_1800_0000) begin
        errors++; $display("FAIL accumulate inst%0d: carry_out=%h required 000018000000", k, co[k]);
      end
    end
  endtask

  task automatic test_stall();
    logic [N-1:0][47:0] s_co;
    logic [N-1:0][15:0] s_dout;
    logic [N-1:0][15:0] s_dcar;
    logic [15:0] hist[$];
    in_mode      = 5'b00000;
    op_mode      = 7'b0000101;
    ce_calculate = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_in = 16'($urandom);
      hist.push_back(data_in);
      step();
    end
    s_co = co; s_dout = dout; s_dcar = dcar;
    ce_calculate = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data_in = 16'($urandom);
      step();
      checks++;
      if (co !== s_co || dout !== s_dout || dcar !== s_dcar) begin
        errors++;
        $display("FAIL stall_hold cycle%0d: carry_out=%h data_out=%h data_carry=%h, required %h %h %h",
                 i, co, dout, dcar, s_co, s_dout, s_dcar);
      end
    end
    ce_calculate = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_in = 16'($urandom);
      hist.push_back(data_in);
      step();
      checks++;
      if (dcar[1] !== hist[hist.size()-2]) begin
        errors++; $display("FAIL stall_lag2: data_carry=%h required %h", dcar[1], hist[hist.size()-2]);
      end
      for (int k = 0; k < N; k++) begin
        logic [47:0] ec;
        logic [15:0] ed;
        longint sh;
        ec = mp[k][47:0];
        sh = mp[k] >>> lsb[k];
        ed = (last[k] != 0) ? sh[15:0] : 16'h0;
        checks++;
        if (co[k] !== ec || dout[k] !== ed || dcar[k] !== md[k][dregs[k]-1]) begin
          errors++;
          $display("FAIL stall_resume inst%0d: carry_out=%h data_out=%h data_carry=%h, required %h %h %h",
                   k, co[k], dout[k], dcar[k], ec, ed, md[k][dregs[k]-1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    run_mac(16'h2000, 7'b0000101, 3);
    checks++;
    if (co[0] !== 48'h0000_0800_0000) begin
      errors++; $display("FAIL pre_reset_p: carry_out=%h required 000008000000", co[0]);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (co[k] !== 48'h0 || dout[k] !== 16'h0 || dcar[k] !== 16'h0) begin
        errors++;
        $display("FAIL mid_reset inst%0d: carry_out=%h data_out=%h data_carry=%h, required all zero",
                 k, co[k], dout[k], dcar[k]);
      end
    end
    run_mac(16'h2000, 7'b0000101, 3);
    checks++;
    if (dout[0] !== 16'h1000) begin
      errors++; $display("FAIL coef_retained: data_out=%h required 1000", dout[0]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset          = ($urandom_range(0, 31) == 0);
      ce_calculate   = ($urandom_range(0, 3) != 0);
      ce_coefficient = ($urandom_range(0, 3) == 0);
      data_in        = 16'($urandom);
      coefficient_in = 16'($urandom);
      carry_in       = 48'({$urandom(), $urandom()});
      in_mode        = 5'($urandom);
      op_mode        = {3'($urandom_range(0, 4)),
                        ($urandom_range(0, 3) != 0) ? 4'b0101 : 4'($urandom)};
      step();
      for (int k = 0; k < N; k++) begin
        logic [47:0] ec;
        logic [15:0] ed;
        longint sh;
        ec = mp[k][47:0];
        sh = mp[k] >>> lsb[k];
        ed = (last[k] != 0) ? sh[15:0] : 16'h0;
        checks++;
        if (co[k] !== ec || dout[k] !== ed || dcar[k] !== md[k][dregs[k]-1]) begin
          errors++;
          $display("FAIL random inst%0d cycle%0d: carry_out=%h data_out=%h data_carry=%h, required %h %h %h",
                   k, i, co[k], dout[k], dcar[k], ec, ed, md[k][dregs[k]-1]);
        end
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      md[k][0] = '0; md[k][1] = '0;
      mc[k][0] = '0; mc[k][1] = '0;
      mm[k] = 0; mp[k] = 0;
    end
    reset          = 1'b1;
    data_in        = '0;
    coefficient_in = '0;
    carry_in       = '0;
    ce_calculate   = 1'b0;
    ce_coefficient = 1'b0;
    op_mode        = '0;
    in_mode        = '0;
    test_reset();
    test_basic_multiply();
    test_cascade();
    test_negative();
    test_accumulate();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multiply_accumulate_behavioural.md
Name: multiply_accumulate_behavioural

Overview:
- Behavioural, synthesizable model of one DSP48E1-style multiply-accumulate slice.
- It provides a registered data input, a registered coefficient, a multiply register (M), a post-adder and an accumulator/output register (P), plus data and carry cascade ports.
- Slices chain into a systolic FIR filter: first slice, middle slices, last slice.
- Only the last slice drives a scaled, truncated output sample.

Parameters:
- DATA_WIDTH, 16, width of signed data in/out and data cascade.
- COEFFICIENT_WIDTH, 16, width of signed coefficient.
- CARRY_WIDTH, 48, width of the P register and of the carry cascade.
- OUTPUT_OFFSET, 0, signed bit shift applied to the data_out slice position.
- DATA_IN_NUMBER_REGS, 1, data register stages; legal values 1 or 2.
- COEFFICIENTS_NUMBER_REGS, 2, coefficient register stages; legal values 1 or 2.
- USE_SILICON_CARRY, 1, cascade-routing hint only; has no functional effect.
- FIRST_IN_CHAIN, 0, 1 means carry_in is ignored and treated as zero.
- LAST_IN_CHAIN, 0, 1 means data_out is driven; 0 means data_out is held at zero.

Ports:
- clock  in  1  single clock; all registers update on the rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  DATA_WIDTH  signed sample, or cascaded data from the previous slice.
- coefficient_in  in  COEFFICIENT_WIDTH  signed coefficient write data.
- carry_in  in  CARRY_WIDTH  signed partial sum from the previous slice.
- carry_out  out  CARRY_WIDTH  the P register, for the next slice.
- data_carry  out  DATA_WIDTH  last data register, for the next slice.
- data_out  out  DATA_WIDTH  scaled output slice of P.
- ce_calculate  in  1  enable for the data, M and P registers.
- ce_coefficient  in  1  load enable for coefficient stage 1.
- op_mode  in  7  selects the adder inputs: X=[1:0], Y=[3:2], Z=[6:4].
- in_mode  in  5  bit 0 selects the multiplier data source; bits [4:1] are reserved and ignored.

Behaviour:
- All arithmetic is signed two's complement.
- Data registers (D1, and D2 if 2 stages):
  - On ce_calculate: D1 <= data_in and D2 <= D1.
  - data_carry = last stage (D1 or D2).
- Multiplier data operand:
  - in_mode[0]=1 selects D1.
  - in_mode[0]=0 selects the last stage.
  - With 1 stage, both choices are D1.
- Coefficient registers (C1, and C2 if 2 stages):
  - C1 <= coefficient_in when ce_coefficient=1.
  - C2 <= C1 every clock, unconditionally.
  - The multiplier uses the last stage.
- M register:
  - On ce_calculate, M <= data × coefficient (full DATA_WIDTH+COEFFICIENT_WIDTH product).
  - M is sign-extended to CARRY_WIDTH.
- Adder: P <= XY + Z on ce_calculate.
  - XY = M when X=01 and Y=01; otherwise XY = 0.
  - Z=000 gives 0.
  - Z=001 gives carry_in, or 0 when FIRST_IN_CHAIN=1.
  - Z=010 gives P (accumulate).
  - Any other Z value gives 0.
  - The sum wraps modulo 2^CARRY_WIDTH; no saturation.
- All registers hold their value when the relevant enable is 0.
- carry_out = P.
- data_out (LAST_IN_CHAIN=1) = P[DATA_WIDTH+COEFFICIENT_WIDTH-2+OUTPUT_OFFSET : COEFFICIENT_WIDTH-1+OUTPUT_OFFSET].
  - This is plain truncation: no rounding, no saturation.
  - OUTPUT_OFFSET values that push the slice outside P are illegal.
- Latency, counted in ce_calculate cycles:
  - data_in to P: DATA_IN_NUMBER_REGS+2, or 3 when in_mode[0]=1.
  - carry_in to P: 1.
- Reset:
  - Clears D1, D2, M and P, so carry_out=0, data_out=0 and data_carry=0.
  - Coefficient registers are NOT reset. The filter resets at every frame end and coefficients must survive.
  - Reset has priority over ce_calculate and ce_coefficient.
- ce_coefficient and ce_calculate may be asserted in the same cycle.
  - The product formed that cycle uses the old last-stage coefficient.
  - The new coefficient takes effect on the following cycle, or the one after when there are 2 stages.

Decomposition:
- Shared package holds the op_mode field constants:
  - OPMODE_X_M / OPMODE_Y_M (01).
  - OPMODE_Z_ZERO (000), OPMODE_Z_PCIN (001), OPMODE_Z_P (010).
  - INMODE_A1_SEL bit index.
- The package also holds default widths: 16/16/48.
- One natural sub-module, mac_delay_reg: a parameterized enabled register chain, used for both the data and coefficient pipelines.
- Everything else stays flat.

Test Plan:
All cases use 16/16/48 and OUTPUT_OFFSET=0 unless noted.
1. Basic multiply:
   - Setup: coefficient 0x4000 loaded (two ce_coefficient-enabled cycles or wait), op_mode 0000101, in_mode 00001, data_in 0x2000 held with ce_calculate=1, LAST_IN_CHAIN=1.
   - Required: P=0x0000_0800_0000 and data_out=0x1000 after 3 enabled cycles.
2. Cascade:
   - Setup: FIRST_IN_CHAIN=0, op_mode 0010101, carry_in=0x0000_0000_0100, product zero.
   - Required: next P=0x100. With FIRST_IN_CHAIN=1 the same stimulus gives P=0.
3. Negative numbers:
   - Setup: data 0xFFFF (−1) × coefficient 0x0003.
   - Required: P=0xFFFF_FFFF_FFFD (sign-extended); data_out=0xFFFF after truncation.
4. Stall:
   - Stimulus: drop ce_calculate for 5 cycles mid-stream while changing data_in.
   - Required: D, M, P and data_carry hold; the pipeline resumes with identical results. With DATA_IN_NUMBER_REGS=2, data_carry lags data_in by exactly 2 enabled cycles.
5. Reset mid-operation:
   - Stimulus: assert reset with P≠0.
   - Required: next cycle P, data_out, carry_out and data_carry are 0; the coefficient is retained, so re-applying data 0x2000 again gives data_out 0x1000 with no reload.
6. Offset and accumulate:
   - Stimulus: op_mode Z=010 over three products of 0x0800_0000; also OUTPUT_OFFSET=−2.
   - Required: P accumulates to 0x1800_0000. With OUTPUT_OFFSET=−2, a single product of 0x0800_0000 gives data_out 0x4000.
